// File: rtl/qadd_vec_pipe_if.sv
// qadd_vec_pipe_if: input-beat and output-result handshake bundle for qadd_vec_pipe
interface qadd_vec_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES = 4
);
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic mode;
  logic [LANES*DATA_WIDTH-1:0] a;
  logic [LANES*DATA_WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic [LANES-1:0] out_ovf;
  modport master (
    output in_valid, in_last, mode, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
  modport slave (
    input  in_valid, in_last, mode, a, b, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/qadd_vec_pipe.sv
// qadd_vec_pipe: pipelined LANES-wide signed adder / packet accumulator.
// Define QADD_VEC_SATURATE_EN to clamp overflowing lanes instead of wrapping.
module qadd_vec_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES = 4
) (
  input logic clk,
  input logic resetn,
  qadd_vec_pipe_if.slave bus
);
  localparam int W = LANES*DATA_WIDTH;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic [W-1:0] acc, nxt, out_data;
  logic [LANES-1:0] ovf, sticky, out_ovf;
  logic out_valid, in_ready, acc_mode, accept, load;
  // acc is zero whenever IDLE, so a first accumulate beat reduces to a+0
  always_comb begin
    acc_mode = state == ACCUM || bus.mode;
    in_ready = (state == ACCUM && !bus.in_last) || !out_valid || bus.out_ready;
    accept = bus.in_valid && in_ready;
    load = accept && (!acc_mode || bus.in_last);
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] x, y;
    logic [DATA_WIDTH:0] sum;
    assign x = bus.a[i*DATA_WIDTH +: DATA_WIDTH];
    assign y = acc_mode ? acc[i*DATA_WIDTH +: DATA_WIDTH] : bus.b[i*DATA_WIDTH +: DATA_WIDTH];
    assign sum = {x[DATA_WIDTH-1], x} + {y[DATA_WIDTH-1], y};
    assign ovf[i] = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
`ifdef QADD_VEC_SATURATE_EN
    assign nxt[i*DATA_WIDTH +: DATA_WIDTH] = ovf[i] ? {sum[DATA_WIDTH], {(DATA_WIDTH-1){~sum[DATA_WIDTH]}}} : sum[DATA_WIDTH-1:0];
`else
    assign nxt[i*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      acc <= '0;
      sticky <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ovf <= '0;
    end else begin
      if (load) begin
        out_data <= nxt;
        out_ovf <= sticky | ovf;
      end
      out_valid <= load || (out_valid && !bus.out_ready);
      if (accept && acc_mode) begin
        acc <= bus.in_last ? '0 : nxt;
        sticky <= bus.in_last ? '0 : sticky | ovf;
        state <= bus.in_last ? IDLE : ACCUM;
      end
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_ovf = out_ovf;
endmodule

// File: tb/tb_qadd_vec_pipe.sv
// tb_qadd_vec_pipe: directed and random checks of qadd_vec_pipe against an integer reference model
module tb_qadd_vec_pipe;
  localparam int DW = 16;
  localparam int LN = 4;
  localparam int W = DW*LN;
  localparam int MAXV = 2**(DW-1) - 1;
  localparam int MINV = -(2**(DW-1));
`ifdef QADD_VEC_SATURATE_EN
  localparam logic [15:0] POS_OVF = 16'h7FFF;
  localparam logic [15:0] NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] POS_OVF = 16'h8000;
  localparam logic [15:0] NEG_OVF = 16'h7FFF;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;
  qadd_vec_pipe_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();
  qadd_vec_pipe #(.DATA_WIDTH(DW), .LANES(LN)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int errors = 0;
  int checks = 0;
  bit m_ov, m_inpkt;
  logic [W-1:0] m_od;
  logic [LN-1:0] m_oo, m_stk;
  int m_acc [LN];
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void lane_add(input int x, input int y, output int r, output bit o);
    int s;
    s = x + y;
    o = s > MAXV || s < MINV;
`ifdef QADD_VEC_SATURATE_EN
    r = s > MAXV ? MAXV : s < MINV ? MINV : s;
`else
    r = s > MAXV ? s - 2**DW : s < MINV ? s + 2**DW : s;
`endif
  endfunction
  function automatic int lane(input logic [W-1:0] v, input int i);
    return int'($signed(v[i*DW +: DW]));
  endfunction
  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < LN; i++) begin
      case ($urandom_range(0, 3))
        0: v[i*DW +: DW] = 16'h7FF0 + 16'($urandom_range(0, 15));
        1: v[i*DW +: DW] = 16'h8000 + 16'($urandom_range(0, 15));
        2: v[i*DW +: DW] = 16'($urandom_range(0, 7)) - 16'd3;
        default: v[i*DW +: DW] = 16'($urandom);
      endcase
    end
    return v;
  endfunction
  task automatic model_reset();
    m_ov = 0;
    m_inpkt = 0;
    m_od = '0;
    m_oo = '0;
    m_stk = '0;
    foreach (m_acc[i]) m_acc[i] = 0;
  endtask
  // one clock: drive, check outputs at the falling edge, advance the model
  task automatic beat(input bit v, input bit l, input bit m, input logic [W-1:0] av, input logic [W-1:0] bv, input bit ordy);
    bit rdy, ld, o;
    int r;
    logic [W-1:0] nd;
    logic [LN-1:0] no;
    bus.in_valid = v;
    bus.in_last = l;
    bus.mode = m;
    bus.a = av;
    bus.b = bv;
    bus.out_ready = ordy;
    @(negedge clk);
    rdy = !m_ov || ordy || (m_inpkt && !l);
    chk("in_ready", W'(bus.in_ready), W'(rdy));
    chk("out_valid", W'(bus.out_valid), W'(m_ov));
    if (m_ov) begin
      chk("out_data", bus.out_data, m_od);
      chk("out_ovf", W'(bus.out_ovf), W'(m_oo));
    end
    ld = 0;
    nd = '0;
    no = '0;
    if (v && rdy) begin
      if (!m_inpkt && !m) begin
        for (int i = 0; i < LN; i++) begin
          lane_add(lane(av, i), lane(bv, i), r, o);
          nd[i*DW +: DW] = r[DW-1:0];
          no[i] = o;
        end
        ld = 1;
      end else begin
        for (int i = 0; i < LN; i++) begin
          lane_add(lane(av, i), m_acc[i], r, o);
          nd[i*DW +: DW] = r[DW-1:0];
          no[i] = o | m_stk[i];
          m_acc[i] = l ? 0 : r;
          m_stk[i] = l ? 1'b0 : m_stk[i] | o;
        end
        ld = l;
        m_inpkt = !l;
      end
    end
    if (ld) begin
      m_ov = 1;
      m_od = nd;
      m_oo = no;
    end else if (ordy) m_ov = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int hold);
    bus.in_valid = 0;
    #2 resetn = 0;
    #1;
    chk("rst_out_valid", W'(bus.out_valid), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_ovf", W'(bus.out_ovf), '0);
    model_reset();
    repeat (hold) @(posedge clk);
    @(negedge clk) resetn = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.mode = 0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1;
    model_reset();
    do_reset(2);
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    beat(1, 0, 0, {16'h0, 16'h0, 16'hFFFF, 16'h0003}, {16'h0, 16'h0, 16'h0001, 16'h0004}, 1);
    chk("add_valid", W'(bus.out_valid), W'(1));
    chk("add_lane0", W'(bus.out_data[15:0]), W'(16'h0007));
    chk("add_lane1", W'(bus.out_data[31:16]), W'(16'h0000));
    chk("add_ovf", W'(bus.out_ovf), '0);
    beat(1, 0, 0, {32'h0, 16'h8000, 16'h7FFF}, {32'h0, 16'hFFFF, 16'h0001}, 1);
    chk("ovf_lane0", W'(bus.out_data[15:0]), W'(POS_OVF));
    chk("ovf_lane1", W'(bus.out_data[31:16]), W'(NEG_OVF));
    chk("ovf_flags", W'(bus.out_ovf), W'(4'b0011));
    for (int k = 1; k <= 4; k++) begin
      beat(1, k == 4, 1, W'(k), '0, 1);
      chk("acc_valid", W'(bus.out_valid), W'(k == 4));
    end
    chk("acc_sum", W'(bus.out_data[15:0]), W'(16'h000A));
    beat(0, 0, 0, '0, '0, 1);
    chk("acc_pulse", W'(bus.out_valid), '0);
    beat(1, 0, 0, rnd_vec(), rnd_vec(), 1);
    for (int k = 0; k < 3; k++) begin
      beat(1, 0, 0, rnd_vec(), rnd_vec(), 0);
      chk("bp_in_ready", W'(bus.in_ready), '0);
    end
    for (int k = 0; k < 4; k++) beat(1, 0, 0, rnd_vec(), rnd_vec(), 1);
    beat(1, 0, 1, W'(10), '0, 1);
    beat(1, 0, 0, W'(20), W'(7), 1);
    beat(1, 1, 0, W'(30), W'(7), 1);
    chk("modechg_sum", W'(bus.out_data[15:0]), W'(16'd60));
    beat(1, 0, 0, rnd_vec(), rnd_vec(), 0);
    do_reset(1);
    beat(1, 0, 1, W'(3), '0, 1);
    beat(1, 0, 1, W'(4), '0, 1);
    do_reset(1);
    beat(1, 1, 1, W'(5), '0, 1);
    chk("post_rst_valid", W'(bus.out_valid), W'(1));
    chk("post_rst_data", bus.out_data, W'(5));
    for (int k = 0; k < 400; k++)
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           rnd_vec(), rnd_vec(), $urandom_range(0, 3) != 0);
    beat(0, 0, 0, '0, '0, 1);
    beat(0, 0, 0, '0, '0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
